// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cla_pkg
//  Description : Shared byte width and sequencer state encoding for the
//                time-multiplexed CLA adder.
//  Revision    : 1.0
// ============================================================================
package cla_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cla8b.sv
`default_nettype none
// ============================================================================
//  Module      : cla8b
//  Description : Combinational 8-bit carry-lookahead adder.
//  Revision    : 1.0
// ============================================================================
module cla8b
    import cla_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W-1:0] w_g;
    logic [BYTE_W-1:0] w_p;
    logic [BYTE_W:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each carry is formed from the generate/propagate terms of all lower bits.
    always_comb begin
        w_c = '0;
        for (int i = 0; i <= BYTE_W; i++) begin
            logic w_t;
            w_t = cin;
            for (int j = 0; j < i; j++) begin
                w_t = w_g[j] | (w_p[j] & w_t);
            end
            w_c[i] = w_t;
        end
    end

    assign sum  = w_p ^ w_c[BYTE_W-1:0];
    assign cout = w_c[BYTE_W];

endmodule
`default_nettype wire

// File: rtl/cla8b_multibyte_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cla8b_multibyte_sequencer
//  Description : NBYTES-wide add/subtract using one shared 8-bit CLA, one
//                byte per clock, LSB first, with a start/done handshake.
//  Revision    : 1.0
// ============================================================================
module cla8b_multibyte_sequencer
    import cla_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     op_sub,
    input  logic                     cin_ext,
    input  logic [NBYTES*BYTE_W-1:0] a_in,
    input  logic [NBYTES*BYTE_W-1:0] b_in,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [NBYTES*BYTE_W-1:0] result,
    output logic                     cout,
    output logic                     overflow
);

    localparam int                 W      = NBYTES * BYTE_W;
    localparam int                 IDX_W  = $clog2(NBYTES);
    localparam logic [IDX_W-1:0]   C_LAST = IDX_W'(NBYTES - 1);

    state_t             r_state;
    state_t             w_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_result;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;

    logic               w_accept;
    logic               w_last;
    logic [BYTE_W-1:0]  w_a_byte;
    logic [BYTE_W-1:0]  w_b_byte;
    logic [BYTE_W-1:0]  w_sum;
    logic               w_cout;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_idx == C_LAST);

    always_comb begin
        w_a_byte = '0;
        w_b_byte = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_a_byte = r_a[k*BYTE_W +: BYTE_W];
                w_b_byte = r_b[k*BYTE_W +: BYTE_W];
            end
        end
    end

    cla8b u_cla8b (
        .a    (w_a_byte),
        .b    (w_b_byte),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        ready  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Subtraction is A + ~B + 1, so B is inverted at capture and the carry seeded to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a_in;
            r_b      <= op_sub ? ~b_in : b_in;
            r_carry  <= op_sub | cin_ext;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (r_state == S_RUN) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (r_idx == IDX_W'(k)) begin
                    r_result[k*BYTE_W +: BYTE_W] <= w_sum;
                end
            end
            r_carry <= w_cout;
            if (w_last) begin
                r_idx  <= '0;
                r_cout <= w_cout;
                r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_sum[BYTE_W-1] != r_a[W-1]);
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cla8b_multibyte_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla8b_multibyte_sequencer
//  Description : Self-checking bench: directed vector table, multi-cycle
//                corner sequences and random back-to-back operations.
//  Revision    : 1.0
// ============================================================================
module tb_cla8b_multibyte_sequencer;

    localparam int NBYTES = 4;
    localparam int W      = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         op_sub;
    logic         cin_ext;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla8b_multibyte_sequencer #(.NBYTES(NBYTES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_sub   (op_sub),
        .cin_ext  (cin_ext),
        .a_in     (a_in),
        .b_in     (b_in),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain wide integer arithmetic; overflow from the signed range.
    function automatic logic [33:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub, input logic cin);
        longint unsigned u;
        longint          s;
        logic [W-1:0]    r;
        logic            co;
        logic            ov;
        if (sub) begin
            r  = a - b;
            co = (a >= b);
            s  = longint'($signed(a)) - longint'($signed(b));
        end else begin
            u  = longint'(a) + longint'(b) + longint'(cin);
            r  = u[31:0];
            co = u[32];
            s  = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        end
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {ov, co, r};
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_wait", 64'(ready), 64'd1);
    endtask

    // Presents one operation, scrambles inputs after acceptance, returns latency to done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin, output int lat);
        wait_ready();
        a_in    = a;
        b_in    = b;
        op_sub  = sub;
        cin_ext = cin;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        a_in    = $urandom;
        b_in    = $urandom;
        op_sub  = 1'($urandom_range(0, 1));
        cin_ext = 1'($urandom_range(0, 1));
        lat = 1;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          cnt;
        int          rdy_hi;
        int          done_at;
        int          cyc;
        int          accepted;
        int          done_seen;
        int          last_acc;
        logic [33:0] exp_v;
        logic [33:0] exp_q[$];

        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
        vecs[5] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_0007, 32'h0000_0007, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[7] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0};

        rst_n   = 1'b0;
        start   = 1'b0;
        op_sub  = 1'b0;
        cin_ext = 1'b0;
        a_in    = '0;
        b_in    = '0;
        #3;
        check("reset_ready",    64'(ready),    64'd1);
        check("reset_busy",     64'(busy),     64'd0);
        check("reset_done",     64'(done),     64'd0);
        check("reset_result",   64'(result),   64'd0);
        check("reset_cout",     64'(cout),     64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, lat);
            check($sformatf("vec%0d_latency", i),  64'(lat),      64'(NBYTES + 1));
            check($sformatf("vec%0d_result", i),   64'(result),   64'(vecs[i].res));
            check($sformatf("vec%0d_cout", i),     64'(cout),     64'(vecs[i].co));
            check($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(vecs[i].ov));
            tick();
            check($sformatf("vec%0d_hold", i),
                  {29'd0, ready, done, overflow, cout, result},
                  {29'd0, 1'b1, 1'b0, vecs[i].ov, vecs[i].co, vecs[i].res});
        end

        // Asynchronous reset in the middle of an operation.
        wait_ready();
        a_in    = 32'h0000_00FF;
        b_in    = 32'h0000_00FF;
        op_sub  = 1'b0;
        cin_ext = 1'b0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("midrun_busy",   64'(busy),   64'd1);
        check("midrun_byte0", 64'(result), 64'h0000_00FE);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ready",  64'(ready),  64'd1);
        check("async_rst_busy",   64'(busy),   64'd0);
        check("async_rst_result", 64'(result), 64'd0);
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) cnt++;
            tick();
        end
        check("rst_no_done", 64'(cnt), 64'd0);

        // Start pulsed while busy must be ignored.
        wait_ready();
        a_in    = 32'h0000_0010;
        b_in    = 32'h0000_0020;
        op_sub  = 1'b0;
        cin_ext = 1'b0;
        start   = 1'b1;
        tick();
        rdy_hi  = 0;
        done_at = 0;
        for (int c = 1; c <= NBYTES + 1; c++) begin
            if (c == 2) begin
                start = 1'b1;
                a_in  = 32'hAAAA_AAAA;
                b_in  = 32'h5555_5555;
            end else begin
                start = 1'b0;
            end
            if (ready) rdy_hi++;
            if (done && done_at == 0) begin
                done_at = c;
                check("busy_start_result", 64'(result), 64'h0000_0030);
            end
            tick();
        end
        start = 1'b0;
        check("busy_start_ready_low", 64'(rdy_hi),  64'd0);
        check("busy_start_done_at",   64'(done_at), 64'(NBYTES + 1));
        check("busy_start_idle",      {62'd0, ready, busy}, {62'd0, 1'b1, 1'b0});
        tick();
        check("busy_start_not_queued", {62'd0, ready, busy}, {62'd0, 1'b1, 1'b0});

        // Start held high: random operands every cycle, compared against the model.
        cyc       = 0;
        accepted  = 0;
        done_seen = 0;
        last_acc  = -1;
        while (done_seen < 1000 && cyc < 20000) begin
            a_in    = $urandom;
            b_in    = $urandom;
            op_sub  = 1'($urandom_range(0, 1));
            cin_ext = 1'($urandom_range(0, 1));
            start   = (accepted < 1000);
            if (start && ready) begin
                exp_q.push_back(model(a_in, b_in, op_sub, cin_ext));
                if (last_acc >= 0) check("b2b_spacing", 64'(cyc - last_acc), 64'(NBYTES + 2));
                last_acc = cyc;
                accepted++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("b2b_unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("b2b_result", {30'd0, overflow, cout, result}, {30'd0, exp_v});
                end
                done_seen++;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        check("b2b_done_count", 64'(done_seen), 64'd1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
